// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes (common with decode),
// 64-bit constants and the multiply/divide FSM states.
package ex_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] ZERO64     = 64'h0000_0000_0000_0000;
    localparam logic [XLEN-1:0] ALL_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_AND    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, fixed 65-cycle latency.
module muldiv
    import ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  alu_op_e       op,
    input  logic [63:0]   a,
    input  logic [63:0]   b,
    output logic          busy,
    output logic          done,
    output logic [63:0]   result
);

    md_state_e    state;
    logic [5:0]   count;
    logic         finish;
    logic [127:0] acc;
    logic [63:0]  mcand;
    logic         neg_q;
    logic         neg_r;
    logic         div_zero;
    logic         hi_half;
    logic         want_rem;

    logic         sign_a;
    logic         sign_b;
    logic [63:0]  a_mag;
    logic [63:0]  b_mag;
    logic         start_div;
    logic [64:0]  sum;
    logic [127:0] mul_next;
    logic [64:0]  trial;
    logic [63:0]  diff;
    logic [127:0] div_next;
    logic [127:0] prod;
    logic [63:0]  quot;
    logic [63:0]  remd;

    assign sign_a    = a[63] && (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    assign sign_b    = b[63] && (op inside {ALU_MULH, ALU_DIV, ALU_REM});
    assign a_mag     = sign_a ? -a : a;
    assign b_mag     = sign_b ? -b : b;
    assign start_div = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign sum      = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, mcand} : 65'd0);
    assign mul_next = {sum, acc[63:1]};
    assign trial    = {acc[127:64], acc[63]};
    assign diff     = trial[63:0] - mcand;
    assign div_next = (trial >= {1'b0, mcand}) ? {diff, acc[62:0], 1'b1}
                                               : {trial[63:0], acc[62:0], 1'b0};

    assign prod   = neg_q ? -acc : acc;
    assign quot   = div_zero ? ALL_ONES64 : (neg_q ? -acc[63:0] : acc[63:0]);
    assign remd   = neg_r ? -acc[127:64] : acc[127:64];
    assign result = (state == DIV) ? (want_rem ? remd : quot)
                                   : (hi_half ? prod[127:64] : prod[63:0]);
    assign busy   = (state != IDLE);
    assign done   = finish;

    // After 64 iterations finish is set; the following edge hands the result over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 6'd0;
            finish   <= 1'b0;
            acc      <= '0;
            mcand    <= ZERO64;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_half  <= 1'b0;
            want_rem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= start_div ? DIV : MUL;
                        count    <= 6'd0;
                        finish   <= 1'b0;
                        acc      <= {ZERO64, start_div ? a_mag : b_mag};
                        mcand    <= start_div ? b_mag : a_mag;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= (b == ZERO64);
                        hi_half  <= (op != ALU_MUL);
                        want_rem <= op inside {ALU_REM, ALU_REMU};
                    end
                end
                MUL, DIV: begin
                    if (finish) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                    end else begin
                        acc   <= (state == MUL) ? mul_next : div_next;
                        count <= count + 6'd1;
                        if (count == 6'd63) begin
                            finish <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle ALU plus the multiply/divide unit, feeding one
// output register that pulses valid_o toward writeback.
module ex
    import ex_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [63:0]  operand1_i,
    input  logic [63:0]  operand2_i,
    input  logic [4:0]   aluop_i,
    input  logic [4:0]   rd_i,
    input  logic         rf_wen_i,
    input  logic [63:0]  pc_i,
    input  logic         exit_i,
    output logic         valid_o,
    output logic [63:0]  result_o,
    output logic [4:0]   rd_o,
    output logic         rf_wen_o,
    output logic [63:0]  pc_o,
    output logic         exit_o
);

    alu_op_e     op;
    logic [5:0]  shamt;
    logic        is_m;
    logic        accept;
    logic [63:0] alu_result;
    logic        md_busy;
    logic        md_done;
    logic [63:0] md_result;
    logic [4:0]  pend_rd;
    logic        pend_wen;
    logic [63:0] pend_pc;
    logic        pend_exit;

    assign op      = alu_op_e'(aluop_i);
    assign shamt   = operand2_i[5:0];
    assign is_m    = is_muldiv(op);
    assign ready_o = !md_busy && !rst;
    assign accept  = valid_i && ready_o;

    always_comb begin
        alu_result = ZERO64;
        case (op)
            ALU_ADD:  alu_result = operand1_i + operand2_i;
            ALU_SUB:  alu_result = operand1_i - operand2_i;
            ALU_SLT:  alu_result = {63'd0, $signed(operand1_i) < $signed(operand2_i)};
            ALU_SLTU: alu_result = {63'd0, operand1_i < operand2_i};
            ALU_XOR:  alu_result = operand1_i ^ operand2_i;
            ALU_OR:   alu_result = operand1_i | operand2_i;
            ALU_AND:  alu_result = operand1_i & operand2_i;
            ALU_SLL:  alu_result = operand1_i << shamt;
            ALU_SRL:  alu_result = operand1_i >> shamt;
            ALU_SRA:  alu_result = 64'($signed(operand1_i) >>> shamt);
            default:  alu_result = ZERO64;
        endcase
    end

    muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_m),
        .op     (op),
        .a      (operand1_i),
        .b      (operand2_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Writeback fields of an in-flight M op wait here until the unit finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd   <= 5'd0;
            pend_wen  <= 1'b0;
            pend_pc   <= ZERO64;
            pend_exit <= 1'b0;
        end else if (accept && is_m) begin
            pend_rd   <= rf_wen_i ? rd_i : 5'd0;
            pend_wen  <= rf_wen_i;
            pend_pc   <= pc_i;
            pend_exit <= exit_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o  <= 1'b0;
            result_o <= ZERO64;
            rd_o     <= 5'd0;
            rf_wen_o <= 1'b0;
            pc_o     <= ZERO64;
            exit_o   <= 1'b0;
        end else if (md_done) begin
            valid_o  <= 1'b1;
            result_o <= md_result;
            rd_o     <= pend_rd;
            rf_wen_o <= pend_wen;
            pc_o     <= pend_pc;
            exit_o   <= pend_exit;
        end else if (accept && !is_m) begin
            valid_o  <= 1'b1;
            result_o <= alu_result;
            rd_o     <= rf_wen_i ? rd_i : 5'd0;
            rf_wen_o <= rf_wen_i;
            pc_o     <= pc_i;
            exit_o   <= exit_i;
        end else begin
            valid_o  <= 1'b0;
        end
    end

endmodule
